alu_issue_arbiter: RTL and testbench



---
 rtl/alu_issue_arbiter.sv | 76 +++++++
 tb/tb_alu_issue_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: two-requester ALU issue FSM (IDLE/EXEC/RESP) with flag register.
// Optional round-robin tie-breaking via `define ALU_ARB_ROUND_ROBIN_EN.
module alu_issue_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [69:0] req0_cmd,
  input  logic [69:0] req1_cmd,
  output logic [3:0]  alu_op,
  output logic        alu_sdir,
  output logic        alu_sop,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_flags,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  flags_q,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic owner;
  logic [1:0] grant;
  logic accept;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic lastGrant;
  always_comb grant = (req_valid == 2'b11) ? (lastGrant ? 2'b01 : 2'b10) : req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`else
  always_comb grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`endif
  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign accept = |(req_valid & req_ready);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      {alu_op, alu_sdir, alu_sop, alu_a, alu_b} <= '0;
      rsp_valid <= 2'b00;
      rsp_data <= '0;
      rsp_flags <= '0;
      flags_q <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      lastGrant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= req_ready[1];
          {alu_op, alu_sdir, alu_sop, alu_a, alu_b} <= req_ready[1] ? req1_cmd : req0_cmd;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          lastGrant <= req_ready[1];
`endif
          state <= EXEC;
        end
        EXEC: begin
          rsp_data <= alu_res;
          rsp_flags <= alu_flags;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          // shifts (0100) and ops >= 0110 leave architectural flags untouched
          if (alu_op <= 4'd3 || alu_op == 4'd5) flags_q <= alu_flags;
          state <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed self-checking bench with a behavioural ALU model.
module tb_alu_issue_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = 2'b00, req_ready, rsp_valid, rsp_ready = 2'b00;
  logic [69:0] req0_cmd = '0, req1_cmd = '0;
  logic [3:0] alu_op, alu_flags, rsp_flags, flags_q;
  logic alu_sdir, alu_sop, busy;
  logic [31:0] alu_a, alu_b, alu_res, rsp_data;
  int errors = 0, checks = 0;

  alu_issue_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd), .alu_op(alu_op), .alu_sdir(alu_sdir),
    .alu_sop(alu_sop), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags_q(flags_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // external ALU: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 shift, 5 XOR, else pass a
  logic [32:0] sum;
  logic cy, ov;
  always_comb begin
    sum = 33'd0;
    cy = 1'b0;
    ov = 1'b0;
    case (alu_op)
      4'd0: alu_res = alu_a & alu_b;
      4'd1: alu_res = alu_a | alu_b;
      4'd2: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = sum[31:0];
        cy = sum[32];
        ov = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'd3: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_res = sum[31:0];
        cy = sum[32];
        ov = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'd4: alu_res = !alu_sdir ? alu_a << alu_b[4:0] : alu_sop ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
      4'd5: alu_res = alu_a ^ alu_b;
      default: alu_res = alu_a;
    endcase
    alu_flags = {alu_res == 32'd0, alu_res[31], cy, ov};
  end

  function automatic logic [69:0] mk(input logic [3:0] op, input logic sdir, input logic sop,
                                     input logic [31:0] a, input logic [31:0] b);
    return {op, sdir, sop, a, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] expGrant [4];

  initial begin
    tick();
    tick();
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_flags_q", 32'(flags_q), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    req_valid = 2'b00;
    rst = 1'b0;
    // V1: req0 ADD overflow
    req0_cmd = mk(4'd2, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    chk("v1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("v1_exec_busy", 32'(busy), 32'h1);
    chk("v1_exec_ready", 32'(req_ready), 32'h0);
    chk("v1_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("v1_alu_op", 32'(alu_op), 32'h2);
    chk("v1_alu_a", alu_a, 32'h7FFFFFFF);
    chk("v1_alu_b", alu_b, 32'h1);
    tick();
    chk("v1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("v1_rsp_data", rsp_data, 32'h80000000);
    chk("v1_rsp_flags", 32'(rsp_flags), 32'h5);
    chk("v1_flags_q", 32'(flags_q), 32'h5);
    tick();
    chk("v1_idle_busy", 32'(busy), 32'h0);
    chk("v1_idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("v1_hold_alu_a", alu_a, 32'h7FFFFFFF);
    // V3: shift left leaves flags_q alone
    req0_cmd = mk(4'd4, 1'b0, 1'b0, 32'h3, 32'h4);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("v3_rsp_data", rsp_data, 32'h30);
    chk("v3_rsp_flags", 32'(rsp_flags), 32'h0);
    chk("v3_flags_q", 32'(flags_q), 32'h5);
    tick();
    // V4: req1 SUB, owner stalls 5 cycles, non-owner ready ignored
    req1_cmd = mk(4'd3, 1'b0, 1'b0, 32'h5, 32'h5);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1;
    chk("v4_req_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("v4_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("v4_rsp_data", rsp_data, 32'h0);
      chk("v4_rsp_flags", 32'(rsp_flags), 32'hA);
      chk("v4_req_ready", 32'(req_ready), 32'h0);
      chk("v4_busy", 32'(busy), 32'h1);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    tick();
    chk("v4_idle_busy", 32'(busy), 32'h0);
    chk("v4_flags_q", 32'(flags_q), 32'hA);
    // op 0110 holds flags
    req0_cmd = mk(4'd6, 1'b0, 1'b0, 32'h0, 32'h0);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("op6_rsp_flags", 32'(rsp_flags), 32'h8);
    chk("op6_flags_q", 32'(flags_q), 32'hA);
    tick();
    // V5: reset during EXEC
    req0_cmd = mk(4'd2, 1'b0, 1'b0, 32'h1, 32'h1);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("v5_exec_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("v5_busy", 32'(busy), 32'h0);
    chk("v5_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("v5_flags_q", 32'(flags_q), 32'h0);
    chk("v5_alu_op", 32'(alu_op), 32'h0);
    chk("v5_rsp_data", rsp_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("v5_no_rsp", 32'(rsp_valid), 32'h0);
    end
    // reset during RESP
    req1_cmd = mk(4'd1, 1'b0, 1'b0, 32'hF0, 32'h0F);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    chk("rr_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rr_rsp_data", rsp_data, 32'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_after_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rr_after_busy", 32'(busy), 32'h0);
    chk("rr_after_data", rsp_data, 32'h0);
    // V2: both requesters valid continuously
`ifdef ALU_ARB_ROUND_ROBIN_EN
    expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req0_cmd = mk(4'd2, 1'b0, 1'b0, 32'h1, 32'h1);
    req1_cmd = mk(4'd2, 1'b0, 1'b0, 32'h2, 32'h2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("v2_grant", 32'(req_ready), 32'(expGrant[k]));
      tick();
      tick();
      chk("v2_rsp_valid", 32'(rsp_valid), 32'(expGrant[k]));
      chk("v2_rsp_data", rsp_data, expGrant[k][1] ? 32'h4 : 32'h2);
      tick();
    end
    req_valid = 2'b00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
